// File: rtl/dmem_wait_responder_if.sv
// Single-port processor data bus between the core (master) and a data memory (slave).
interface dmem_wait_responder_if;
  logic        memwrite;
  logic        memread;
  logic [31:0] dataadr;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        ready;

  modport master (
    output memwrite, memread, dataadr, writedata,
    input  readdata, ready
  );

  modport slave (
    input  memwrite, memread, dataadr, writedata,
    output readdata, ready
  );
endinterface

// File: rtl/dmem_wait_responder.sv
// Data memory with a programmable wait-state handshake and a sticky store checker
// that reports pass (done) or fail from committed stores.
module dmem_wait_responder #(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned WAIT_STATES = 2,
  parameter int unsigned DONE_ADDR   = 84,
  parameter int unsigned DONE_DATA   = 7,
  parameter int unsigned ALLOW_ADDR  = 80
) (
  input  logic                 clk,
  input  logic                 reset,
  dmem_wait_responder_if.slave bus,
  output logic                 done,
  output logic                 fail,
  output logic [15:0]          wr_count
);

  localparam int unsigned      IDX_W      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int unsigned      CNT_W      = 4;
  localparam logic [CNT_W-1:0] WCNT_INIT  = (WAIT_STATES > 0) ? CNT_W'(WAIT_STATES - 1) : '0;
  localparam logic [31:0]      BYTE_LIMIT = 32'(4 * DEPTH_WORDS);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] wcnt_q, wcnt_d;
  logic             accept;
  logic             op_wr_q;
  logic [31:0]      addr_q, wdata_q;
  logic [31:0]      readdata_q;
  logic             ready_q;
  logic [31:0]      mem [DEPTH_WORDS];

  logic             in_idle, enter_resp, cur_wr, addr_ok;
  logic [31:0]      cur_addr, cur_wdata;
  logic [IDX_W-1:0] idx;

  // Next-state logic for the IDLE -> WAIT -> RESP handshake
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    accept  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.memwrite || bus.memread) begin
          accept = 1'b1;
          if (WAIT_STATES > 0) begin
            state_d = S_WAIT;
            wcnt_d  = WCNT_INIT;
          end else begin
            state_d = S_RESP;
          end
        end
      end
      S_WAIT: begin
        if (wcnt_q == '0) state_d = S_RESP;
        else              wcnt_d  = wcnt_q - CNT_W'(1);
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // With no wait states the commit coincides with accept, so use the live bus in IDLE
  always_comb begin
    in_idle    = (state_q == S_IDLE);
    cur_wr     = in_idle ? bus.memwrite  : op_wr_q;
    cur_addr   = in_idle ? bus.dataadr   : addr_q;
    cur_wdata  = in_idle ? bus.writedata : wdata_q;
    enter_resp = (state_d == S_RESP) && (state_q != S_RESP);
    addr_ok    = (cur_addr[1:0] == 2'b00) && (cur_addr < BYTE_LIMIT);
    idx        = cur_addr[IDX_W+1:2];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      wcnt_q  <= '0;
      op_wr_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      if (accept) begin
        op_wr_q <= bus.memwrite;
        addr_q  <= bus.dataadr;
        wdata_q <= bus.writedata;
      end
    end
  end

  // Response path and RAM; RAM contents survive reset but no write happens during it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      readdata_q <= '0;
      ready_q    <= 1'b0;
      wr_count   <= '0;
    end else begin
      ready_q <= enter_resp;
      if (enter_resp) begin
        readdata_q <= (!cur_wr && addr_ok) ? mem[idx] : '0;
      end else if (state_q == S_RESP) begin
        readdata_q <= '0;
      end
      if (enter_resp && cur_wr && addr_ok) begin
        mem[idx] <= cur_wdata;
        if (wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
      end
    end
  end

  // Checker judges the raw address at accept; the first verdict freezes both flags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      done <= 1'b0;
      fail <= 1'b0;
    end else if (accept && bus.memwrite && !done && !fail) begin
      if (bus.dataadr == 32'(DONE_ADDR) && bus.writedata == 32'(DONE_DATA)) begin
        done <= 1'b1;
      end else if (bus.dataadr != 32'(ALLOW_ADDR)) begin
        fail <= 1'b1;
      end
    end
  end

  assign bus.readdata = readdata_q;
  assign bus.ready    = ready_q;

endmodule

// File: tb/tb_dmem_wait_responder.sv
// Bench for dmem_wait_responder: directed vector table, hand sequences, and
// randomized transactions checked against an array-based memory/checker model.
module tb_dmem_wait_responder;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  dmem_wait_responder_if bus2();
  dmem_wait_responder_if bus0();

  logic        done2, fail2, done0, fail0;
  logic [15:0] cnt2, cnt0;

  dmem_wait_responder #(.WAIT_STATES(2)) dut (
    .clk(clk), .reset(reset), .bus(bus2), .done(done2), .fail(fail2), .wr_count(cnt2)
  );

  dmem_wait_responder #(.WAIT_STATES(0)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0), .done(done0), .fail(fail0), .wr_count(cnt0)
  );

  int checks = 0;
  int failures = 0;

  typedef struct {
    bit          rst;
    logic        we;
    logic        re;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp_rd;
    logic        exp_done;
    logic        exp_fail;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t tbl[20];

  // Behavioural model: per-instance RAM image plus checker flags and store count
  logic [31:0] m_mem  [2][64];
  bit          m_val  [2][64];
  bit          m_done [2];
  bit          m_fail [2];
  int          m_cnt  [2];

  function automatic vec_t mk(input bit rst, input logic we, input logic re,
                              input logic [31:0] a, input logic [31:0] d, input logic [31:0] rd,
                              input logic dn, input logic fl, input logic [15:0] c);
    vec_t v;
    v.rst = rst; v.we = we; v.re = re; v.addr = a; v.data = d;
    v.exp_rd = rd; v.exp_done = dn; v.exp_fail = fl; v.exp_cnt = c;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic get_ready(input int s);
    return (s == 0) ? bus2.ready : bus0.ready;
  endfunction
  function automatic logic [31:0] get_rd(input int s);
    return (s == 0) ? bus2.readdata : bus0.readdata;
  endfunction
  function automatic logic get_done(input int s);
    return (s == 0) ? done2 : done0;
  endfunction
  function automatic logic get_fail(input int s);
    return (s == 0) ? fail2 : fail0;
  endfunction
  function automatic logic [15:0] get_cnt(input int s);
    return (s == 0) ? cnt2 : cnt0;
  endfunction

  task automatic drive(input int s, input logic we, input logic re,
                       input logic [31:0] a, input logic [31:0] d);
    if (s == 0) begin
      bus2.memwrite = we; bus2.memread = re; bus2.dataadr = a; bus2.writedata = d;
    end else begin
      bus0.memwrite = we; bus0.memread = re; bus0.dataadr = a; bus0.writedata = d;
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
    for (int s = 0; s < 2; s++) begin
      chk("rst_ready", 32'(get_ready(s)), 32'd0);
      chk("rst_readdata", get_rd(s), 32'd0);
      chk("rst_done", 32'(get_done(s)), 32'd0);
      chk("rst_fail", 32'(get_fail(s)), 32'd0);
      chk("rst_wr_count", 32'(get_cnt(s)), 32'd0);
      m_done[s] = 1'b0; m_fail[s] = 1'b0; m_cnt[s] = 0;
    end
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  // One request held until ready; checks latency, pulse width and readdata clearing
  task automatic xact(input int s, input logic we, input logic re,
                      input logic [31:0] a, input logic [31:0] d, input bit scramble,
                      output logic [31:0] rd_seen);
    int lat;
    bit got;
    lat = 0;
    got = 1'b0;
    drive(s, we, re, a, d);
    while (!got && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (scramble && lat == 1 && !get_ready(s)) drive(s, we, re, $urandom, $urandom);
      if (get_ready(s)) got = 1'b1;
    end
    rd_seen = get_rd(s);
    chk((s == 0) ? "latency_ws2" : "latency_ws0", 32'(lat), (s == 0) ? 32'd3 : 32'd1);
    drive(s, 1'b0, 1'b0, 32'd0, 32'd0);
    @(posedge clk); #1;
    chk("ready_pulse", 32'(get_ready(s)), 32'd0);
    chk("readdata_clear", get_rd(s), 32'd0);
  endtask

  task automatic model_check(input int s, input logic we, input logic [31:0] a,
                             input logic [31:0] d, input logic [31:0] rd);
    bit ok;
    int unsigned idx;
    ok  = (a[1:0] == 2'b00) && (a < 32'd256);
    idx = 32'(a >> 2) & 32'd63;
    if (we) begin
      if (!m_done[s] && !m_fail[s]) begin
        if (a == 32'd84 && d == 32'd7) m_done[s] = 1'b1;
        else if (a != 32'd80)          m_fail[s] = 1'b1;
      end
      if (ok) begin
        m_mem[s][idx] = d;
        m_val[s][idx] = 1'b1;
        if (m_cnt[s] < 65535) m_cnt[s]++;
      end
      chk("rnd_write_rd", rd, 32'd0);
    end else if (!ok) begin
      chk("rnd_bad_addr_rd", rd, 32'd0);
    end else if (m_val[s][idx]) begin
      chk("rnd_read", rd, m_mem[s][idx]);
    end
    chk("rnd_done", 32'(get_done(s)), 32'(m_done[s]));
    chk("rnd_fail", 32'(get_fail(s)), 32'(m_fail[s]));
    chk("rnd_wr_count", 32'(get_cnt(s)), 32'(m_cnt[s]));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic [31:0] a, d;
    logic        we, re;
    int          s, op;

    drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(1, 1'b0, 1'b0, 32'd0, 32'd0);

    tbl[0]  = mk(1'b1, 1'b1, 1'b0, 32'd80,  32'd3,          32'd0,          1'b0, 1'b0, 16'd1);
    tbl[1]  = mk(1'b0, 1'b1, 1'b0, 32'd84,  32'd7,          32'd0,          1'b1, 1'b0, 16'd2);
    tbl[2]  = mk(1'b0, 1'b1, 1'b0, 32'd88,  32'd1,          32'd0,          1'b1, 1'b0, 16'd3);
    tbl[3]  = mk(1'b0, 1'b1, 1'b0, 32'd0,   32'hA5A5_0001,  32'd0,          1'b1, 1'b0, 16'd4);
    tbl[4]  = mk(1'b0, 1'b0, 1'b1, 32'd0,   32'd0,          32'hA5A5_0001,  1'b1, 1'b0, 16'd4);
    tbl[5]  = mk(1'b0, 1'b1, 1'b0, 32'd256, 32'd5,          32'd0,          1'b1, 1'b0, 16'd4);
    tbl[6]  = mk(1'b0, 1'b1, 1'b0, 32'd2,   32'h0000_DEAD,  32'd0,          1'b1, 1'b0, 16'd4);
    tbl[7]  = mk(1'b0, 1'b0, 1'b1, 32'd0,   32'd0,          32'hA5A5_0001,  1'b1, 1'b0, 16'd4);
    tbl[8]  = mk(1'b0, 1'b0, 1'b1, 32'd256, 32'd0,          32'd0,          1'b1, 1'b0, 16'd4);
    tbl[9]  = mk(1'b0, 1'b0, 1'b1, 32'd2,   32'd0,          32'd0,          1'b1, 1'b0, 16'd4);
    tbl[10] = mk(1'b0, 1'b1, 1'b1, 32'd8,   32'd5,          32'd0,          1'b1, 1'b0, 16'd5);
    tbl[11] = mk(1'b0, 1'b0, 1'b1, 32'd8,   32'd0,          32'd5,          1'b1, 1'b0, 16'd5);
    tbl[12] = mk(1'b1, 1'b1, 1'b0, 32'd84,  32'd6,          32'd0,          1'b0, 1'b1, 16'd1);
    tbl[13] = mk(1'b0, 1'b1, 1'b0, 32'd84,  32'd7,          32'd0,          1'b0, 1'b1, 16'd2);
    tbl[14] = mk(1'b0, 1'b0, 1'b1, 32'd84,  32'd0,          32'd7,          1'b0, 1'b1, 16'd2);
    tbl[15] = mk(1'b1, 1'b1, 1'b0, 32'd100, 32'd7,          32'd0,          1'b0, 1'b1, 16'd1);
    tbl[16] = mk(1'b1, 1'b1, 1'b0, 32'd256, 32'd1,          32'd0,          1'b0, 1'b1, 16'd0);
    tbl[17] = mk(1'b1, 1'b1, 1'b0, 32'd80,  32'd9,          32'd0,          1'b0, 1'b0, 16'd1);
    tbl[18] = mk(1'b0, 1'b0, 1'b1, 32'd80,  32'd0,          32'd9,          1'b0, 1'b0, 16'd1);
    tbl[19] = mk(1'b0, 1'b0, 1'b1, 32'd0,   32'd0,          32'hA5A5_0001,  1'b0, 1'b0, 16'd1);

    do_reset();

    for (int i = 0; i < 20; i++) begin
      if (tbl[i].rst) do_reset();
      xact(0, tbl[i].we, tbl[i].re, tbl[i].addr, tbl[i].data, 1'b0, rd);
      chk($sformatf("vec%0d_readdata", i), rd, tbl[i].exp_rd);
      chk($sformatf("vec%0d_done", i), 32'(done2), 32'(tbl[i].exp_done));
      chk($sformatf("vec%0d_fail", i), 32'(fail2), 32'(tbl[i].exp_fail));
      chk($sformatf("vec%0d_wr_count", i), 32'(cnt2), 32'(tbl[i].exp_cnt));
    end

    // Zero wait states: single-cycle turnaround
    do_reset();
    xact(1, 1'b1, 1'b0, 32'd4, 32'h0000_1234, 1'b0, rd);
    xact(1, 1'b0, 1'b1, 32'd4, 32'd0, 1'b0, rd);
    chk("ws0_read", rd, 32'h0000_1234);
    chk("ws0_wr_count", 32'(cnt0), 32'd1);

    // Reset during WAIT abandons the store
    do_reset();
    xact(0, 1'b1, 1'b0, 32'd12, 32'h0000_1111, 1'b0, rd);
    drive(0, 1'b1, 1'b0, 32'd12, 32'd9);
    @(posedge clk); #1;
    chk("midrst_no_ready", 32'(bus2.ready), 32'd0);
    do_reset();
    xact(0, 1'b0, 1'b1, 32'd12, 32'd0, 1'b0, rd);
    chk("midrst_ram_kept", rd, 32'h0000_1111);
    chk("midrst_wr_count", 32'(cnt2), 32'd0);

    // Randomized traffic against the model
    for (int s2 = 0; s2 < 2; s2++)
      for (int w = 0; w < 64; w++) m_val[s2][w] = 1'b0;
    do_reset();
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 24) == 0) do_reset();
      s  = int'($urandom_range(0, 1));
      op = int'($urandom_range(0, 9));
      we = (op < 5) || (op == 9);
      re = (op >= 5);
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5: a = 32'($urandom_range(0, 15)) << 2;
        6:       a = 32'd80;
        7:       a = 32'd84;
        8:       a = ($urandom_range(0, 1) == 0) ? (32'd256 + (32'($urandom_range(0, 63)) << 2))
                                                 : ($urandom | 32'h0000_1000);
        default: a = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(1, 3));
      endcase
      d = ($urandom_range(0, 3) == 0) ? 32'd7 : $urandom;
      if (we && $urandom_range(0, 5) == 0) begin
        a = 32'd84;
        d = 32'd7;
      end
      xact(s, we, re, a, d, 1'b1, rd);
      model_check(s, we, a, d, rd);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
